instr_fetch_unit: RTL and testbench

//   Instruction fetch sequencer feeding the opcode/literal pair into control_unit.

---
 rtl/instr_fetch_unit.sv | 73 +++++++
 tb/tb_instr_fetch_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC sequencer fetching {opcode, literal} words and handing them to execute via valid/ack
module instr_fetch_unit #(
  parameter int PC_W  = 8,
  parameter int OP_W  = 7,
  parameter int LIT_W = 8,
  parameter logic [OP_W-1:0] HALT_OP = {OP_W{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [PC_W-1:0]       imem_addr,
  input  logic                  imem_valid,
  input  logic [OP_W+LIT_W-1:0] imem_data,
  output logic [OP_W-1:0]       opcode,
  output logic [LIT_W-1:0]      literal,
  output logic                  instr_valid,
  input  logic                  instr_ack,
  input  logic                  lPC,
  input  logic [PC_W-1:0]       jump_addr,
  output logic [PC_W-1:0]       pc,
  output logic                  halted
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALTED} state_t;
  state_t r_state, w_next;
  logic [PC_W-1:0]  r_pc;
  logic [OP_W-1:0]  r_op;
  logic [LIT_W-1:0] r_lit;
  logic             r_req, r_valid, r_halted;
  logic [OP_W-1:0]  w_op;
  logic             w_capture, w_retire;
  assign w_op      = imem_data[OP_W+LIT_W-1:LIT_W];
  assign w_capture = (r_state == FETCH) && imem_valid;
  assign w_retire  = (r_state == HOLD) && instr_ack;
  // next-state decode; imem_valid only matters while a fetch is outstanding
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = FETCH;
      FETCH:   w_next = imem_valid ? ((w_op == HALT_OP) ? HALTED : HOLD) : FETCH;
      HOLD:    w_next = instr_ack ? FETCH : HOLD;
      default: w_next = HALTED;
    endcase
  end
  // state, registered handshake outputs, captured instruction and PC update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_pc     <= '0;
      r_op     <= '0;
      r_lit    <= '0;
      r_req    <= 1'b0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_req    <= (w_next == FETCH);
      r_valid  <= (w_next == HOLD);
      r_halted <= (w_next == HALTED);
      if (w_capture) begin
        r_op  <= w_op;
        r_lit <= imem_data[LIT_W-1:0];
      end
      if (w_retire) r_pc <= lPC ? jump_addr : r_pc + PC_W'(1);
    end
  end
  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign opcode      = r_op;
  assign literal     = r_lit;
  assign instr_valid = r_valid;
  assign halted      = r_halted;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench with a wait-state imem model for instr_fetch_unit
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid;
  logic [14:0] imem_data;
  logic [6:0]  opcode;
  logic [7:0]  literal;
  logic        instr_valid;
  logic        instr_ack;
  logic        lPC;
  logic [7:0]  jump_addr;
  logic [7:0]  pc;
  logic        halted;
  logic [14:0] mem [256];
  logic [14:0] q [$];
  logic [7:0]  exp_pc;
  logic        force_valid;
  int          lat, cnt, n_chk, n_pass;
  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data), .opcode(opcode), .literal(literal),
    .instr_valid(instr_valid), .instr_ack(instr_ack), .lPC(lPC), .jump_addr(jump_addr),
    .pc(pc), .halted(halted)
  );
  always #5 clk = ~clk;
  assign imem_data  = mem[imem_addr];
  assign imem_valid = force_valid || (imem_req && cnt >= lat);
  // wait-state counter: cycles the current request has been outstanding
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 0;
    else cnt <= (imem_req && !imem_valid) ? cnt + 1 : 0;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic fetch_one(input logic lpc, input logic [7:0] ja, input int wl);
    int n;
    logic [14:0] d;
    lat = wl;
    n = 0;
    while (!imem_req && n < 20) begin @(negedge clk); n++; end
    chk("req", imem_req, 1);
    chk("addr", imem_addr, exp_pc);
    q.push_back(mem[exp_pc]);
    n = 0;
    while (!instr_valid && n < 20) begin
      @(negedge clk); n++;
      if (!instr_valid) begin
        chk("wait_req", imem_req, 1);
        chk("wait_addr", imem_addr, exp_pc);
      end
    end
    chk("latency", n, wl + 1);
    d = q.pop_front();
    chk("opcode", opcode, d[14:8]);
    chk("literal", literal, d[7:0]);
    chk("req_low_hold", imem_req, 0);
    lPC = 1'b1; jump_addr = ~ja;
    @(negedge clk);
    chk("noack_pc", pc, exp_pc);
    chk("noack_valid", instr_valid, 1);
    chk("noack_opcode", opcode, d[14:8]);
    lPC = lpc; jump_addr = ja; instr_ack = 1'b1;
    @(negedge clk);
    instr_ack = 1'b0; lPC = 1'b0;
    exp_pc = lpc ? ja : exp_pc + 8'd1;
    chk("pc", pc, exp_pc);
    chk("valid_clr", instr_valid, 0);
    chk("req_after_ack", imem_req, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int bad_v, bad_r;
    n_chk = 0; n_pass = 0; lat = 0; force_valid = 1'b0;
    instr_ack = 1'b0; lPC = 1'b0; jump_addr = '0; exp_pc = '0;
    for (int i = 0; i < 256; i++) mem[i] = {7'(i & 63), 8'(i * 3 + 1)};
    mem[0]  = {7'h01, 8'hAA};
    mem[80] = {7'h7F, 8'h5C};
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc", pc, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_literal", literal, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 0);
    fetch_one(1'b0, 8'h00, 0);
    fetch_one(1'b0, 8'h00, 3);
    fetch_one(1'b1, 8'h40, 0);
    fetch_one(1'b1, 8'hFF, 1);
    fetch_one(1'b0, 8'h00, 0);
    fetch_one(1'b1, 8'h50, 0);
    lat = 0;
    chk("halt_addr", imem_addr, 8'h50);
    bad_v = 0; bad_r = 0;
    repeat (20) begin
      @(negedge clk);
      if (instr_valid) bad_v++;
      if (imem_req) bad_r++;
    end
    chk("halt_flag", halted, 1);
    chk("halt_no_valid", bad_v, 0);
    chk("halt_no_req", bad_r, 0);
    chk("halt_pc", pc, 8'h50);
    chk("halt_opcode", opcode, 7'h7F);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_halted", halted, 0);
    rst_n = 1'b1; exp_pc = '0;
    @(negedge clk);
    fetch_one(1'b1, 8'h30, 0);
    lat = 10;
    repeat (3) @(negedge clk);
    chk("mid_req", imem_req, 1);
    chk("mid_addr", imem_addr, 8'h30);
    #2 rst_n = 1'b0;
    #1;
    chk("async_req", imem_req, 0);
    chk("async_pc", pc, 0);
    chk("async_opcode", opcode, 0);
    chk("async_literal", literal, 0);
    force_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("stale_valid", instr_valid, 0);
    chk("restart_req", imem_req, 1);
    chk("restart_addr", imem_addr, 0);
    force_valid = 1'b0;
    q.delete();
    exp_pc = '0;
    fetch_one(1'b0, 8'h00, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
